ex_stage: RTL and testbench

- Execute stage of the pipelined MIPS core, directly downstream of the ALU decoder. It consumes the 3-bit alucontrol code plus decode-stage operands and control.
- Holds the ID/EX pipeline register, forwarding muxes and ALU, and registers results into the EX/MEM register for the memory stage.
- Supports hazard-unit stall/flush and a valid bit per stage.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/ex_stage_alu.sv | 44 ++++
 rtl/ex_stage.sv | 151 +++++++++++++++
 tb/tb_ex_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS execute stage: ALU codes, forward selects, ID/EX control bundle.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic [2:0] alucontrol;
    logic [4:0] writereg;
  } idex_ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: add/sub/and/or/slt with wrap-around, zero flag, illegal-code and signed-overflow flags.
module alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    illegal  = 1'b0;
    overflow = 1'b0;
    case (alucontrol)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, forwarding muxes, ALU, EX/MEM register with stall/flush and per-stage valid.
// Optional EX_OVERFLOW_TRAP_EN adds ovf_m and suppresses regwrite_m on signed add/sub overflow.
module ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [2:0]       alucontrol_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic             alusrc_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic [4:0]       writereg_d,
  input  logic [1:0]       fwd_a_e,
  input  logic [1:0]       fwd_b_e,
  input  logic [WIDTH-1:0] result_w,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic             valid_m,
  output logic [WIDTH-1:0] aluout_m,
  output logic             zero_m,
  output logic [WIDTH-1:0] writedata_m,
  output logic             regwrite_m,
  output logic             memtoreg_m,
  output logic             memwrite_m,
  output logic [4:0]       writereg_m,
  output logic             illegal_m
`ifdef EX_OVERFLOW_TRAP_EN
  ,
  output logic             ovf_m
`endif
);

`ifdef EX_OVERFLOW_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  idex_ctrl_t       ctrl_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
    end else if (flush_e) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
    end else if (!stall_e) begin
      ctrl_q <= '{valid: valid_d, regwrite: regwrite_d, memtoreg: memtoreg_d,
                  memwrite: memwrite_d, alusrc: alusrc_d,
                  alucontrol: alucontrol_d, writereg: writereg_d};
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= signimm_d;
    end
  end

  // Select 2'b11 has no source and falls back to the register-file value.
  logic [WIDTH-1:0] src_a, fwd_b, src_b;
  always_comb begin
    src_a = rd1_q;
    fwd_b = rd2_q;
    case (fwd_a_e)
      FWD_W:   src_a = result_w;
      FWD_M:   src_a = aluout_m;
      default: src_a = rd1_q;
    endcase
    case (fwd_b_e)
      FWD_W:   fwd_b = result_w;
      FWD_M:   fwd_b = aluout_m;
      default: fwd_b = rd2_q;
    endcase
  end
  assign src_b = ctrl_q.alusrc ? imm_q : fwd_b;

  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_ill, alu_ovf;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a         (src_a),
    .b         (src_b),
    .alucontrol(ctrl_q.alucontrol),
    .result    (alu_res),
    .zero      (alu_zero),
    .illegal   (alu_ill),
    .overflow  (alu_ovf)
  );

  logic ovf_e;
  assign ovf_e = ctrl_q.valid & alu_ovf & TRAP_EN;

  logic             valid_q, zero_q, regwrite_q, memtoreg_q, memwrite_q, illegal_q, ovf_q;
  logic [WIDTH-1:0] aluout_q, wdata_q;
  logic [4:0]       writereg_q;

  // A stalled E instruction must not leak into M, so M sees bubbles until stall drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || (stall_e && !flush_e)) begin
      valid_q    <= 1'b0;
      aluout_q   <= '0;
      zero_q     <= 1'b0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      writereg_q <= '0;
      illegal_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= ctrl_q.valid;
      aluout_q   <= alu_res;
      zero_q     <= alu_zero;
      wdata_q    <= fwd_b;
      regwrite_q <= ctrl_q.valid & ctrl_q.regwrite & ~ovf_e;
      memtoreg_q <= ctrl_q.valid & ctrl_q.memtoreg;
      memwrite_q <= ctrl_q.valid & ctrl_q.memwrite;
      writereg_q <= ctrl_q.writereg;
      illegal_q  <= ctrl_q.valid & alu_ill;
      ovf_q      <= ovf_e;
    end
  end

  assign valid_m     = valid_q;
  assign aluout_m    = aluout_q;
  assign zero_m      = zero_q;
  assign writedata_m = wdata_q;
  assign regwrite_m  = regwrite_q;
  assign memtoreg_m  = memtoreg_q;
  assign memwrite_m  = memwrite_q;
  assign writereg_m  = writereg_q;
  assign illegal_m   = illegal_q;
`ifdef EX_OVERFLOW_TRAP_EN
  assign ovf_m       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU ops, forwarding, stall/flush, illegal codes, overflow trap option.
module tb_ex_stage;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_d;
  logic [2:0]       alucontrol_d;
  logic [WIDTH-1:0] rd1_d, rd2_d, signimm_d, result_w;
  logic             alusrc_d, regwrite_d, memtoreg_d, memwrite_d;
  logic [4:0]       writereg_d;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             stall_e, flush_e;
  logic             valid_m, zero_m, regwrite_m, memtoreg_m, memwrite_m, illegal_m;
  logic [WIDTH-1:0] aluout_m, writedata_m;
  logic [4:0]       writereg_m;
`ifdef EX_OVERFLOW_TRAP_EN
  logic             ovf_m;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .alucontrol_d(alucontrol_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d), .alusrc_d(alusrc_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .writereg_d(writereg_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .result_w(result_w), .stall_e(stall_e), .flush_e(flush_e),
    .valid_m(valid_m), .aluout_m(aluout_m), .zero_m(zero_m),
    .writedata_m(writedata_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .memwrite_m(memwrite_m), .writereg_m(writereg_m), .illegal_m(illegal_m)
`ifdef EX_OVERFLOW_TRAP_EN
    , .ovf_m(ovf_m)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src,
                       input logic rw, input logic mw, input logic [4:0] wr);
    valid_d = v; alucontrol_d = op; rd1_d = a; rd2_d = b; signimm_d = imm;
    alusrc_d = src; regwrite_d = rw; memtoreg_d = 1'b0; memwrite_d = mw; writereg_d = wr;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b010, $urandom, $urandom, $urandom, 1'b0, 1'b1, 1'b1, 5'd7);
      fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom); result_w = $urandom;
      tick();
    end
    tests++;
    if ({valid_m, aluout_m, zero_m, writedata_m, regwrite_m, memtoreg_m, memwrite_m, writereg_m, illegal_m} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b alu=%h rw=%b mw=%b wr=%0d, want all 0",
               valid_m, aluout_m, regwrite_m, memwrite_m, writereg_m);
    end
    fwd_a_e = 2'b00; fwd_b_e = 2'b00; result_w = '0; idle();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 3'b010, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 5'd9);
    tick(); idle(); tick();
    tests++;
    if (aluout_m !== 32'd12 || zero_m !== 1'b0 || regwrite_m !== 1'b1 || writereg_m !== 5'd9 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL add_basic: got alu=%0d zero=%b rw=%b wr=%0d v=%b, want 12 0 1 9 1",
               aluout_m, zero_m, regwrite_m, writereg_m, valid_m);
    end
  endtask

  task automatic test_sub_slt_imm();
    drive(1'b1, 3'b110, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b1, 1'b0, 5'd3);
    tick();
    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd4);
    tick();
    tests++;
    if (aluout_m !== 32'd0 || zero_m !== 1'b1) begin
      fails++;
      $display("FAIL sub_zero: got alu=%h zero=%b, want 0 1", aluout_m, zero_m);
    end
    drive(1'b1, 3'b010, 32'd10, 32'd99, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 5'd5);
    tick();
    tests++;
    if (aluout_m !== 32'd1 || zero_m !== 1'b0) begin
      fails++;
      $display("FAIL slt_signed: got alu=%h zero=%b, want 1 0", aluout_m, zero_m);
    end
    drive(1'b1, 3'b001, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0, 1'b0, 5'd6);
    tick();
    tests++;
    if (aluout_m !== 32'd8 || writedata_m !== 32'd99 || memwrite_m !== 1'b1) begin
      fails++;
      $display("FAIL imm_store: got alu=%0d wdata=%0d mw=%b, want 8 99 1", aluout_m, writedata_m, memwrite_m);
    end
    idle(); tick();
    tests++;
    if (aluout_m !== 32'hFF || regwrite_m !== 1'b0) begin
      fails++;
      $display("FAIL or_op: got alu=%h rw=%b, want ff 0", aluout_m, regwrite_m);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 5'd8);
    tick();
    drive(1'b1, 3'b010, 32'd50, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd9);
    tick();
    tests++;
    if (aluout_m !== 32'd7) begin
      fails++;
      $display("FAIL b2b_first: got %0d, want 7", aluout_m);
    end
    drive(1'b1, 3'b010, 32'd50, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd10);
    fwd_a_e = 2'b10;
    tick();
    tests++;
    if (aluout_m !== 32'd8) begin
      fails++;
      $display("FAIL fwd_from_m: got %0d, want 8", aluout_m);
    end
    drive(1'b1, 3'b010, 32'd20, 32'd30, 32'd0, 1'b0, 1'b1, 1'b0, 5'd11);
    fwd_a_e = 2'b01; result_w = 32'd100;
    tick();
    tests++;
    if (aluout_m !== 32'd101) begin
      fails++;
      $display("FAIL fwd_from_w: got %0d, want 101", aluout_m);
    end
    idle();
    fwd_a_e = 2'b11; fwd_b_e = 2'b01; result_w = 32'd1000;
    tick();
    tests++;
    if (aluout_m !== 32'd1020 || writedata_m !== 32'd1000) begin
      fails++;
      $display("FAIL fwd_11_and_b: got alu=%0d wdata=%0d, want 1020 1000", aluout_m, writedata_m);
    end
    fwd_a_e = 2'b00; fwd_b_e = 2'b00; result_w = '0;
    tick();
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'b010, 32'd20, 32'd22, 32'd0, 1'b0, 1'b1, 1'b0, 5'd12);
    tick();
    stall_e = 1'b1;
    drive(1'b1, 3'b110, 32'd9, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd13);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (valid_m !== 1'b0 || regwrite_m !== 1'b0) begin
        fails++;
        $display("FAIL stall_bubble_%0d: got valid=%b rw=%b, want 0 0", i, valid_m, regwrite_m);
      end
    end
    stall_e = 1'b0; idle();
    tick();
    tests++;
    if (valid_m !== 1'b1 || aluout_m !== 32'd42 || writereg_m !== 5'd12) begin
      fails++;
      $display("FAIL stall_release: got valid=%b alu=%0d wr=%0d, want 1 42 12", valid_m, aluout_m, writereg_m);
    end
    tick();
    tests++;
    if (valid_m !== 1'b0) begin
      fails++;
      $display("FAIL stall_once: got valid=%b, want 0", valid_m);
    end
    drive(1'b1, 3'b010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    stall_e = 1'b1; flush_e = 1'b1;
    tick();
    tests++;
    if (valid_m !== 1'b1 || memwrite_m !== 1'b1) begin
      fails++;
      $display("FAIL flush_passes_e: got valid=%b mw=%b, want 1 1", valid_m, memwrite_m);
    end
    stall_e = 1'b0; flush_e = 1'b0;
    tick();
    tests++;
    if (valid_m !== 1'b0 || memwrite_m !== 1'b0) begin
      fails++;
      $display("FAIL flush_bubble: got valid=%b mw=%b, want 0 0", valid_m, memwrite_m);
    end
    idle(); tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b100, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 5'd2);
    tick();
    drive(1'b0, 3'b100, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 5'd2);
    tick();
    tests++;
    if (aluout_m !== 32'd0 || illegal_m !== 1'b1 || valid_m !== 1'b1) begin
      fails++;
      $display("FAIL illegal_valid: got alu=%0d ill=%b v=%b, want 0 1 1", aluout_m, illegal_m, valid_m);
    end
    idle(); tick();
    tests++;
    if (illegal_m !== 1'b0 || valid_m !== 1'b0) begin
      fails++;
      $display("FAIL illegal_bubble: got ill=%b v=%b, want 0 0", illegal_m, valid_m);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 5'd14);
    tick(); idle(); tick();
    tests++;
    if (aluout_m !== 32'h8000_0000) begin
      fails++;
      $display("FAIL ovf_wrap: got %h, want 80000000", aluout_m);
    end
`ifdef EX_OVERFLOW_TRAP_EN
    tests++;
    if (ovf_m !== 1'b1 || regwrite_m !== 1'b0) begin
      fails++;
      $display("FAIL ovf_trap: got ovf=%b rw=%b, want 1 0", ovf_m, regwrite_m);
    end
`else
    tests++;
    if (regwrite_m !== 1'b1) begin
      fails++;
      $display("FAIL ovf_no_trap: got rw=%b, want 1", regwrite_m);
    end
`endif
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 3'b010, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 5'd15);
    tick(); tick();
    reset = 1'b0;
    #1;
    tests++;
    if (valid_m !== 1'b0 || aluout_m !== 32'd0 || regwrite_m !== 1'b0 || memwrite_m !== 1'b0) begin
      fails++;
      $display("FAIL reset_midop: got v=%b alu=%0d rw=%b mw=%b, want 0 0 0 0", valid_m, aluout_m, regwrite_m, memwrite_m);
    end
    idle(); tick();
    reset = 1'b1;
    tick();
    tests++;
    if (valid_m !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: got v=%b, want 0", valid_m);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt_imm();
    test_back_to_back();
    test_stall_flush();
    test_illegal();
    test_overflow();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
